// File: rtl/ghidich_8led_if.sv
// LED pattern engine bus: mode select in, LED drive and step pulse out.
// PAUSE exists only when GHIDICH_PAUSE_EN is defined.
interface ghidich_8led_if;
  logic [1:0] MODE;
`ifdef GHIDICH_PAUSE_EN
  logic       PAUSE;
`endif
  logic [7:0] LED;
  logic       STEP;

`ifdef GHIDICH_PAUSE_EN
  modport master (
    output MODE,
    output PAUSE,
    input  LED,
    input  STEP
  );

  modport slave (
    input  MODE,
    input  PAUSE,
    output LED,
    output STEP
  );
`else
  modport master (
    output MODE,
    input  LED,
    input  STEP
  );

  modport slave (
    input  MODE,
    output LED,
    output STEP
  );
`endif
endinterface

// File: rtl/ghidich_8led.sv
// 8-LED pattern engine: rotate L/R, ping-pong, fill/clear with prescaler.
// Optional step freeze input enabled by macro GHIDICH_PAUSE_EN.
module ghidich_8led #(
  parameter int DIV = 25_000_000
) (
  input  logic           CLK,
  input  logic           RST,
  ghidich_8led_if.slave  bus
);

  localparam int CW = $clog2(DIV) + 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  localparam logic [1:0] M_ROL  = 2'd0;
  localparam logic [1:0] M_ROR  = 2'd1;
  localparam logic [1:0] M_PING = 2'd2;
  localparam logic [1:0] M_FILL = 2'd3;

  // dir = 0 means left (ping-pong) or fill (fill/clear)
  logic [7:0]    led_q, led_d;
  logic [1:0]    mode_q, mode_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          step_q, step_d;

  logic [7:0]    seed;
  logic [7:0]    nxt_led;
  logic          nxt_dir;
  logic          chg;
  logic          pause;

`ifdef GHIDICH_PAUSE_EN
  assign pause = bus.PAUSE;
`else
  assign pause = 1'b0;
`endif

  // Seed pattern of the mode being requested
  always_comb begin
    seed = 8'h01;
    unique case (bus.MODE)
      M_ROL:  seed = 8'h01;
      M_ROR:  seed = 8'h80;
      M_PING: seed = 8'h01;
      M_FILL: seed = 8'h00;
    endcase
  end

  // Next LED value and direction for one step of the active mode
  always_comb begin
    nxt_led = led_q;
    nxt_dir = dir_q;
    unique case (mode_q)
      M_ROL: nxt_led = {led_q[6:0], led_q[7]};
      M_ROR: nxt_led = {led_q[0], led_q[7:1]};
      M_PING: begin
        if (!dir_q) begin
          if (led_q == 8'h80) begin
            nxt_led = 8'h40;
            nxt_dir = 1'b1;
          end else begin
            nxt_led = {led_q[6:0], 1'b0};
          end
        end else begin
          if (led_q == 8'h01) begin
            nxt_led = 8'h02;
            nxt_dir = 1'b0;
          end else begin
            nxt_led = {1'b0, led_q[7:1]};
          end
        end
      end
      M_FILL: begin
        if (!dir_q) begin
          if (led_q == 8'hFF) begin
            nxt_led = 8'hFE;
            nxt_dir = 1'b1;
          end else begin
            nxt_led = {led_q[6:0], 1'b1};
          end
        end else begin
          if (led_q == 8'h00) begin
            nxt_led = 8'h01;
            nxt_dir = 1'b0;
          end else begin
            nxt_led = {led_q[6:0], 1'b0};
          end
        end
      end
    endcase
  end

  assign chg = (bus.MODE != mode_q);

  // Next state: mode reload beats pause, pause beats prescaler tick
  always_comb begin
    led_d  = led_q;
    mode_d = mode_q;
    dir_d  = dir_q;
    cnt_d  = cnt_q;
    step_d = 1'b0;
    if (chg) begin
      mode_d = bus.MODE;
      led_d  = seed;
      dir_d  = 1'b0;
      cnt_d  = '0;
    end else if (pause) begin
      cnt_d  = cnt_q;
    end else if (cnt_q == LAST) begin
      cnt_d  = '0;
      led_d  = nxt_led;
      dir_d  = nxt_dir;
      step_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + ONE;
    end
  end

  // State register, async reset to the mode 0 seed
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      led_q  <= 8'h01;
      mode_q <= M_ROL;
      dir_q  <= 1'b0;
      cnt_q  <= '0;
      step_q <= 1'b0;
    end else begin
      led_q  <= led_d;
      mode_q <= mode_d;
      dir_q  <= dir_d;
      cnt_q  <= cnt_d;
      step_q <= step_d;
    end
  end

  // Outputs come straight from registers
  always_comb begin
    bus.LED  = led_q;
    bus.STEP = step_q;
  end

endmodule

// File: tb/tb_ghidich_8led.sv
// Bench for ghidich_8led: DIV=4 and DIV=1 instances vs a sequence-index model.
// Pause checks included when GHIDICH_PAUSE_EN is defined.
module tb_ghidich_8led;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [1:0] mode_s = 2'd0;
  logic       pause_s = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  ghidich_8led_if if4 ();
  ghidich_8led_if if1 ();

  assign if4.MODE = mode_s;
  assign if1.MODE = mode_s;
`ifdef GHIDICH_PAUSE_EN
  assign if4.PAUSE = pause_s;
  assign if1.PAUSE = pause_s;
`endif

  ghidich_8led #(.DIV(4)) u4 (.CLK(CLK), .RST(RST), .bus(if4));
  ghidich_8led #(.DIV(1)) u1 (.CLK(CLK), .RST(RST), .bus(if1));

  always #5 CLK = ~CLK;

  function automatic int per(int m);
    case (m)
      0, 1:    return 8;
      2:       return 14;
      default: return 16;
    endcase
  endfunction

  // i-th pattern value of mode m counted from its seed
  function automatic logic [7:0] seqv(int m, int i);
    int p;
    p = i % per(m);
    case (m)
      0: return 8'(1 << p);
      1: return 8'(128 >> p);
      2: return (p < 8) ? 8'(1 << p) : 8'(1 << (14 - p));
      default: return (p <= 8) ? 8'((1 << p) - 1) : 8'(255 << (p - 8));
    endcase
  endfunction

  function automatic int dv(int k);
    return (k == 0) ? 4 : 1;
  endfunction

  int m_mode[2];
  int m_idx[2];
  int m_cnt[2];
  logic m_step[2];

  // Model: position within the mode's sequence plus cycle phase
  always @(posedge CLK or posedge RST) begin
    for (int k = 0; k < 2; k++) begin
      if (RST) begin
        m_mode[k] <= 0;
        m_idx[k]  <= 0;
        m_cnt[k]  <= 0;
        m_step[k] <= 1'b0;
      end else if (int'(mode_s) != m_mode[k]) begin
        m_mode[k] <= int'(mode_s);
        m_idx[k]  <= 0;
        m_cnt[k]  <= 0;
        m_step[k] <= 1'b0;
      end else if (pause_s) begin
        m_step[k] <= 1'b0;
      end else if (m_cnt[k] == dv(k) - 1) begin
        m_cnt[k]  <= 0;
        m_idx[k]  <= (m_idx[k] + 1) % per(m_mode[k]);
        m_step[k] <= 1'b1;
      end else begin
        m_cnt[k]  <= m_cnt[k] + 1;
        m_step[k] <= 1'b0;
      end
    end
  end

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  bit run = 1'b0;

  // Per-cycle comparison of both instances against the model
  always @(negedge CLK) begin
    if (run) begin
      chk("led4", if4.LED, seqv(m_mode[0], m_idx[0]));
      chk("step4", {7'd0, if4.STEP}, {7'd0, m_step[0]});
      chk("led1", if1.LED, seqv(m_mode[1], m_idx[1]));
      chk("step1", {7'd0, if1.STEP}, {7'd0, m_step[1]});
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    #1 RST = 1'b1;
    #1;
    chk("rst_led4", if4.LED, 8'h01);
    chk("rst_step4", {7'd0, if4.STEP}, 8'h00);
    chk("rst_led1", if1.LED, 8'h01);
    run = 1'b1;
    cyc(1);
    RST = 1'b0;

    cyc(4);
    chk("first_step_led4", if4.LED, 8'h02);
    chk("first_step_stb4", {7'd0, if4.STEP}, 8'h01);
    chk("div1_led_4edges", if1.LED, 8'h10);
    cyc(28);
    chk("rol_wrap_led4", if4.LED, 8'h01);
    chk("rol_wrap_stb4", {7'd0, if4.STEP}, 8'h01);

    cyc(2);
    mode_s = 2'd1;
    cyc(1);
    chk("ror_seed_led4", if4.LED, 8'h80);
    chk("ror_seed_stb4", {7'd0, if4.STEP}, 8'h00);
    cyc(4);
    chk("ror_step_led4", if4.LED, 8'h40);
    chk("ror_step_stb4", {7'd0, if4.STEP}, 8'h01);
    chk("ror_div1_led", if1.LED, 8'h08);

`ifdef GHIDICH_PAUSE_EN
    cyc(2);
    pause_s = 1'b1;
    cyc(10);
    chk("pause_led4", if4.LED, 8'h40);
    chk("pause_stb4", {7'd0, if4.STEP}, 8'h00);
    pause_s = 1'b0;
    cyc(2);
    chk("resume_led4", if4.LED, 8'h20);
    chk("resume_stb4", {7'd0, if4.STEP}, 8'h01);
`endif

    mode_s = 2'd2;
    cyc(1);
    chk("ping_seed", if1.LED, 8'h01);
    chk("ping_seed_stb", {7'd0, if1.STEP}, 8'h00);
    cyc(7);
    chk("ping_top", if1.LED, 8'h80);
    cyc(1);
    chk("ping_turn", if1.LED, 8'h40);
    cyc(6);
    chk("ping_bottom", if1.LED, 8'h01);
    cyc(1);
    chk("ping_turn2", if1.LED, 8'h02);

    mode_s = 2'd3;
    cyc(1);
    chk("fill_seed", if1.LED, 8'h00);
    cyc(8);
    chk("fill_full", if1.LED, 8'hFF);
    cyc(1);
    chk("clear_first", if1.LED, 8'hFE);
    cyc(6);
    chk("clear_80", if1.LED, 8'h80);
    cyc(1);
    chk("clear_empty", if1.LED, 8'h00);
    cyc(1);
    chk("fill_again", if1.LED, 8'h01);

    #2 RST = 1'b1;
    mode_s = 2'd0;
    cyc(1);
    RST = 1'b0;
    cyc(3);
    mode_s = 2'd1;
    cyc(1);
    chk("chg_on_tick_led4", if4.LED, 8'h80);
    chk("chg_on_tick_stb4", {7'd0, if4.STEP}, 8'h00);
    cyc(3);
    chk("chg_no_early_stb4", {7'd0, if4.STEP}, 8'h00);
    cyc(1);
    chk("chg_next_led4", if4.LED, 8'h40);
    chk("chg_next_stb4", {7'd0, if4.STEP}, 8'h01);

    mode_s = 2'd2;
    cyc(1);
    chk("m2_seed_led4", if4.LED, 8'h01);
    cyc(16);
    chk("m2_at10_led4", if4.LED, 8'h10);
    #2 RST = 1'b1;
    #1;
    chk("async_rst_led4", if4.LED, 8'h01);
    chk("async_rst_stb4", {7'd0, if4.STEP}, 8'h00);
    cyc(1);
    RST = 1'b0;
    cyc(1);
    chk("rel_m2_seed_led4", if4.LED, 8'h01);
    chk("rel_m2_seed_stb4", {7'd0, if4.STEP}, 8'h00);

    for (int i = 0; i < 3000; i++) begin
      int r;
      @(negedge CLK);
      r = int'($urandom_range(0, 199));
      if (r < 8) mode_s = 2'($urandom_range(0, 3));
`ifdef GHIDICH_PAUSE_EN
      if (r >= 20 && r < 40) pause_s = ~pause_s;
`endif
      if (r == 100) begin
        #2 RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
      end
    end

    @(negedge CLK);
    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
